sd_cmd_phy: RTL and testbench
=============================

Name: sd_cmd_phy

Overview:
- Card-facing physical layer for the SD host command path. Sits between the host command controller and the SD CMD pin.
- Accepts a 40-bit command frame body on a strobe, appends CRC7 and end bit, and serializes 48 bits MSB-first on the CMD line.
- Then waits for the card response, deserializes it, returns it to the controller under a strobe/ack handshake, and reports timeout if no start bit arrives.

Parameters:
- TIMEOUT_CYCLES, 64, clocks after the end bit within which the response start bit must appear.
- CNT_W, 8, width of the bit/timeout counter; must hold max(136, TIMEOUT_CYCLES).

Ports:
- clock  in  1  SD command clock; one CMD bit per cycle.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- strobe_in  in  1  controller request; frame valid while high.
- ack_in  in  1  controller has consumed the response.
- idle_in  in  1  controller idle indication; forces return to IDLE from DONE/TOUT.
- cmd_to_send  in  40  {start=0, trans=1, index[5:0], argument[31:0]}.
- cmd_pin_in  in  1  sampled CMD line.
- cmd_pin_out  out  1  driven CMD value.
- cmd_pin_oe  out  1  output enable for CMD pad.
- strobe_out  out  1  response/completion valid to controller.
- ack_out  out  1  one-cycle pulse when a frame is latched.
- cmd_response  out  136  received response, right-aligned (R1/R3/R6/R7 in [47:0], R2 in [135:0]).
- timeout  out  1  no response start bit within TIMEOUT_CYCLES.

Behaviour:
- Reset values: cmd_pin_out=1, cmd_pin_oe=0, strobe_out=0, ack_out=0, cmd_response=0, timeout=0, state=IDLE, counter=0.
- Reset mid-operation aborts immediately. The pad is released the next cycle.
- Response class is decoded from cmd_to_send[37:32] latched at LOAD:
  - index 0, 4, 15: no response.
  - index 2, 9, 10: RSP_LEN=136.
  - all others: RSP_LEN=48.
- States:
  - IDLE: oe=0, out=1. A rising edge of strobe_in (high now, low last cycle) goes to LOAD.
  - LOAD: latch frame into 48-bit shift reg upper 40 bits; pulse ack_out for 1 cycle; clear CRC; counter=47; go to SEND.
  - SEND: oe=1.
    - Bits 47..8 shifted out MSB-first while the CRC7 accumulates.
    - Bits 7..1 are the CRC7 (poly x^7+x^3+1, init 0).
    - Bit 0 is the end bit 1.
    - Exactly 48 cycles.
    - No-response commands then go to DONE; otherwise go to WAIT.
  - WAIT: oe=0, counter counts up from 0.
    - cmd_pin_in==0 goes to RECV with that bit as received bit RSP_LEN-1 and counter=RSP_LEN-2.
    - Counter reaching TIMEOUT_CYCLES-1 without a start bit goes to TOUT.
    - The start bit is accepted at count TIMEOUT_CYCLES-1 itself (start wins over timeout).
  - RECV: shift cmd_pin_in into cmd_response LSB; decrement counter. At counter 0 with the last bit sampled, go to DONE. The end bit is stored, not checked.
  - DONE: strobe_out=1 held.
    - ack_in or idle_in goes to IDLE and clears strobe_out.
    - cmd_response holds until the next LOAD, where it is cleared.
  - TOUT: timeout=1 and strobe_out=0 held. Goes to IDLE when strobe_in==0 or idle_in==1.
- strobe_in dropping during SEND/WAIT/RECV does not abort. The transaction completes and sits in DONE until ack_in/idle_in.
- Latency: first CMD bit drives the cycle after LOAD. Total for short response = 2 + 48 + Ncr + 48 cycles to strobe_out.

Optional Feature:
- SD_CMD_RSP_CRC_CHECK_EN: adds output crc_error (1 bit).
  - A second CRC7 is computed over received bits [RSP_LEN-1:8] (R2: bits [127:8] only; R3, index 41, excluded → crc_error=0) and compared with bits [7:1].
  - crc_error is valid with strobe_out and is cleared at LOAD.
- Without the macro: no port, no receive-side CRC logic; response is passed unchecked.

Decomposition:
- Package sd_cmd_pkg holds:
  - state encoding localparams;
  - response-length constants RSP_LEN_SHORT=48 and RSP_LEN_LONG=136;
  - index lists for no-response and long-response classes;
  - CRC7 polynomial constant.
- Sub-module sd_crc7 (serial CRC7: clear, enable, bit in, 7-bit crc out) is instantiated once for TX and once more under the macro for RX.

Test Plan:
- CMD0 arg 0x00000000 → cmd_pin_out stream 48'h4000_0000_0095 with oe=1 for 48 cycles; strobe_out 1 cycle later, timeout=0, cmd_response=0.
- CMD8 arg 0x000001AA, card answers 48'h0800_0001_AA13 after 5 idle cycles → TX 48'h4800_0001_AA87; cmd_response[47:0]=48'h0800_0001_AA13; strobe_out held until ack_in.
- CMD2, card sends 136-bit R2 (bench pattern 0x3F…) → cmd_response[135:0] matches bit-exact; strobe_out after 136 receive cycles.
- CMD17 arg 0, line held 1 → timeout=1 at 64 cycles after end bit; strobe_out=0; deassert strobe_in → IDLE next cycle.
- Start bit arriving exactly at WAIT count 63 → response received, timeout stays 0.
- reset=0 asserted mid-SEND (bit 20) → next cycle oe=0, out=1, all outputs at reset values; new strobe_in edge restarts cleanly.
- Macro on: corrupt one CRC bit of the CMD8 response → crc_error=1; correct CRC → crc_error=0.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// ============================================================================
// Module  : sd_cmd_pkg
// Brief   : Shared constants for the SD command PHY: state codes, response
//           classes and the CRC7 polynomial.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sd_cmd_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_RECV = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_TOUT = 3'd6;

  localparam int RSP_LEN_SHORT = 48;
  localparam int RSP_LEN_LONG  = 136;
  localparam int CMD_LEN       = 48;

  // Command index sets, one bit per index 0..63
  localparam logic [63:0] NO_RSP_IDX_MASK   = (64'd1 << 0) | (64'd1 << 4) | (64'd1 << 15);
  localparam logic [63:0] LONG_RSP_IDX_MASK = (64'd1 << 2) | (64'd1 << 9) | (64'd1 << 10);
  localparam logic [5:0]  IDX_R3            = 6'd41;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  function automatic logic is_no_rsp(input logic [5:0] idx);
    return NO_RSP_IDX_MASK[idx];
  endfunction

  function automatic logic is_long_rsp(input logic [5:0] idx);
    return LONG_RSP_IDX_MASK[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_crc7.sv
// ============================================================================
// Module  : sd_crc7
// Brief   : Serial CRC7 (x^7 + x^3 + 1), one bit per enabled clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       fb;

  always_comb begin
    fb    = bit_i ^ crc_q[6];
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = 7'd0;
    end else if (en_i) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      crc_q <= 7'd0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/sd_cmd_phy.sv
// ============================================================================
// Module  : sd_cmd_phy
// Brief   : SD CMD-line PHY: serializes a command with CRC7, then receives,
//           returns or times out on the card response.
//           Optional define SD_CMD_RSP_CRC_CHECK_EN adds response CRC checking
//           with a crc_error output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sd_cmd_phy
  import sd_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          strobe_in,
  input  logic          ack_in,
  input  logic          idle_in,
  input  logic [39:0]   cmd_to_send,
  input  logic          cmd_pin_in,
  output logic          cmd_pin_out,
  output logic          cmd_pin_oe,
  output logic          strobe_out,
  output logic          ack_out,
  output logic [135:0]  cmd_response,
`ifdef SD_CMD_RSP_CRC_CHECK_EN
  output logic          crc_error,
`endif
  output logic          timeout
);

  localparam logic [CNT_W-1:0] CNT_ZERO       = '0;
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TX_FIRST   = CNT_W'(CMD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_BODY_LAST  = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_TOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_RX_SHORT   = CNT_W'(RSP_LEN_SHORT - 2);
  localparam logic [CNT_W-1:0] CNT_RX_LONG    = CNT_W'(RSP_LEN_LONG - 2);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [39:0]      tx_q, tx_d;
  logic [135:0]     rsp_q, rsp_d;
  logic             no_rsp_q, no_rsp_d;
  logic             long_q, long_d;
  logic             strobe_prev_q;
  logic [6:0]       tx_crc;
  logic             tx_crc_en;

  // ---------------- state register ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (strobe_in && !strobe_prev_q) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (cnt_q == CNT_ZERO) state_d = no_rsp_q ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        // A start bit on the final count still wins over the timeout
        if (!cmd_pin_in)                  state_d = ST_RECV;
        else if (cnt_q == CNT_TOUT_LAST)  state_d = ST_TOUT;
      end
      ST_RECV: if (cnt_q == CNT_ZERO) state_d = ST_DONE;
      ST_DONE: if (ack_in || idle_in) state_d = ST_IDLE;
      ST_TOUT: if (!strobe_in || idle_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    cmd_pin_oe  = (state_q == ST_SEND);
    ack_out     = (state_q == ST_LOAD);
    strobe_out  = (state_q == ST_DONE);
    timeout     = (state_q == ST_TOUT);
    cmd_pin_out = 1'b1;
    if (state_q == ST_SEND) begin
      if (cnt_q >= CNT_BODY_LAST) begin
        cmd_pin_out = tx_q[39];
      end else if (cnt_q != CNT_ZERO) begin
        cmd_pin_out = tx_crc[cnt_q[2:0] - 3'd1];
      end
    end
  end

  assign cmd_response = rsp_q;

  // ---------------- datapath ----------------
  always_comb begin
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    rsp_d    = rsp_q;
    no_rsp_d = no_rsp_q;
    long_d   = long_q;
    case (state_q)
      ST_IDLE: cnt_d = CNT_ZERO;
      ST_LOAD: begin
        tx_d     = cmd_to_send;
        rsp_d    = '0;
        cnt_d    = CNT_TX_FIRST;
        no_rsp_d = is_no_rsp(cmd_to_send[37:32]);
        long_d   = is_long_rsp(cmd_to_send[37:32]);
      end
      ST_SEND: begin
        tx_d  = {tx_q[38:0], 1'b0};
        cnt_d = (cnt_q == CNT_ZERO) ? CNT_ZERO : cnt_q - CNT_ONE;
      end
      ST_WAIT: begin
        if (!cmd_pin_in) begin
          rsp_d = {rsp_q[134:0], cmd_pin_in};
          cnt_d = long_q ? CNT_RX_LONG : CNT_RX_SHORT;
        end else if (cnt_q == CNT_TOUT_LAST) begin
          cnt_d = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RECV: begin
        rsp_d = {rsp_q[134:0], cmd_pin_in};
        cnt_d = (cnt_q == CNT_ZERO) ? CNT_ZERO : cnt_q - CNT_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q         <= '0;
      tx_q          <= '0;
      rsp_q         <= '0;
      no_rsp_q      <= 1'b0;
      long_q        <= 1'b0;
      strobe_prev_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      tx_q          <= tx_d;
      rsp_q         <= rsp_d;
      no_rsp_q      <= no_rsp_d;
      long_q        <= long_d;
      strobe_prev_q <= strobe_in;
    end
  end

  assign tx_crc_en = (state_q == ST_SEND) && (cnt_q >= CNT_BODY_LAST);

  sd_crc7 u_tx_crc (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (state_q == ST_LOAD),
    .en_i   (tx_crc_en),
    .bit_i  (tx_q[39]),
    .crc_o  (tx_crc)
  );

`ifdef SD_CMD_RSP_CRC_CHECK_EN
  localparam logic [CNT_W-1:0] CNT_CRC_HI_SHORT = CNT_W'(RSP_LEN_SHORT - 1);
  localparam logic [CNT_W-1:0] CNT_CRC_HI_LONG  = CNT_W'(127);

  logic       r3_q, r3_d;
  logic       crc_err_q, crc_err_d;
  logic       rx_crc_en;
  logic [6:0] rx_crc;

  // Covered bits run from the top of the response (R2: bit 127) down to bit 8
  always_comb begin
    rx_crc_en = 1'b0;
    if (state_q == ST_WAIT) begin
      rx_crc_en = !cmd_pin_in && !long_q;
    end else if (state_q == ST_RECV) begin
      rx_crc_en = (cnt_q >= CNT_BODY_LAST) &&
                  (cnt_q <= (long_q ? CNT_CRC_HI_LONG : CNT_CRC_HI_SHORT));
    end
  end

  always_comb begin
    r3_d      = r3_q;
    crc_err_d = crc_err_q;
    if (state_q == ST_LOAD) begin
      r3_d      = (cmd_to_send[37:32] == IDX_R3);
      crc_err_d = 1'b0;
    end else if ((state_q == ST_RECV) && (cnt_q == CNT_ZERO)) begin
      crc_err_d = !r3_q && (rx_crc != rsp_d[7:1]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r3_q      <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      r3_q      <= r3_d;
      crc_err_q <= crc_err_d;
    end
  end

  sd_crc7 u_rx_crc (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (state_q == ST_LOAD),
    .en_i   (rx_crc_en),
    .bit_i  (cmd_pin_in),
    .crc_o  (rx_crc)
  );

  assign crc_error = crc_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sd_cmd_phy.sv
// ============================================================================
// Module  : tb_sd_cmd_phy
// Brief   : Self-checking bench for sd_cmd_phy against a frame-level model.
//           Also covers crc_error when SD_CMD_RSP_CRC_CHECK_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sd_cmd_phy;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         strobe_in = 1'b0;
  logic         ack_in = 1'b0;
  logic         idle_in = 1'b0;
  logic [39:0]  cmd_to_send = '0;
  logic         cmd_pin_in = 1'b1;
  logic         cmd_pin_out;
  logic         cmd_pin_oe;
  logic         strobe_out;
  logic         ack_out;
  logic [135:0] cmd_response;
  logic         timeout;
`ifdef SD_CMD_RSP_CRC_CHECK_EN
  logic         crc_error;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sd_cmd_phy #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .strobe_in    (strobe_in),
    .ack_in       (ack_in),
    .idle_in      (idle_in),
    .cmd_to_send  (cmd_to_send),
    .cmd_pin_in   (cmd_pin_in),
    .cmd_pin_out  (cmd_pin_out),
    .cmd_pin_oe   (cmd_pin_oe),
    .strobe_out   (strobe_out),
    .ack_out      (ack_out),
    .cmd_response (cmd_response),
`ifdef SD_CMD_RSP_CRC_CHECK_EN
    .crc_error    (crc_error),
`endif
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // CRC7 as polynomial remainder of d(x)*x^7 over the low nbits of d
  function automatic logic [6:0] crc7_of(input logic [127:0] d, input int nbits);
    logic [134:0] r;
    r = {d, 7'b0};
    for (int i = nbits + 6; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic int rsp_len_of(input logic [5:0] idx);
    if (idx inside {6'd0, 6'd4, 6'd15}) return 0;
    if (idx inside {6'd2, 6'd9, 6'd10}) return 136;
    return 48;
  endfunction

  function automatic logic [135:0] short_rsp(input logic [5:0] idx, input logic [31:0] p);
    logic [39:0] b;
    b = {2'b00, idx, p};
    return {88'b0, b, crc7_of({88'b0, b}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] long_rsp(input logic [119:0] p);
    return {8'h3F, p, crc7_of({8'b0, p}, 120), 1'b1};
  endfunction

  // ncr < 0 means the card never answers
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input int ncr, input logic [135:0] rsp, input logic exit_idle);
    logic [39:0]  body;
    logic [47:0]  exp_tx;
    logic [47:0]  tx;
    logic [135:0] exp_rsp;
    int           len;
    int           oe_bad;
    body   = {2'b01, idx, arg};
    exp_tx = {body, crc7_of({88'b0, body}, 40), 1'b1};
    len    = rsp_len_of(idx);
    @(negedge clock);
    cmd_to_send = body;
    strobe_in   = 1'b1;
    @(negedge clock);
    check({tag, " ack"}, {135'b0, ack_out}, 136'd1);
    tx     = '0;
    oe_bad = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clock);
      tx = {tx[46:0], cmd_pin_out};
      if (cmd_pin_oe !== 1'b1) oe_bad++;
    end
    check({tag, " tx"}, {88'b0, tx}, {88'b0, exp_tx});
    check({tag, " oe"}, 136'(oe_bad), 136'd0);
    if (len != 0 && ncr < 0) begin
      repeat (64) @(negedge clock);
      check({tag, " no_tout_yet"}, {135'b0, timeout}, 136'd0);
      @(negedge clock);
      check({tag, " tout"}, {135'b0, timeout}, 136'd1);
      check({tag, " tout_strobe"}, {135'b0, strobe_out}, 136'd0);
      check({tag, " tout_rsp"}, cmd_response, 136'd0);
      strobe_in = 1'b0;
      @(negedge clock);
      check({tag, " tout_exit"}, {135'b0, timeout}, 136'd0);
      return;
    end
    exp_rsp = '0;
    if (len != 0) begin
      for (int k = 0; k < ncr; k++) begin
        @(negedge clock);
        cmd_pin_in = 1'b1;
      end
      for (int b = len - 1; b >= 0; b--) begin
        @(negedge clock);
        cmd_pin_in = rsp[b];
      end
      exp_rsp = (len == 48) ? {88'b0, rsp[47:0]} : rsp;
    end
    @(negedge clock);
    cmd_pin_in = 1'b1;
    check({tag, " strobe"}, {135'b0, strobe_out}, 136'd1);
    check({tag, " timeout"}, {135'b0, timeout}, 136'd0);
    check({tag, " rsp"}, cmd_response, exp_rsp);
`ifdef SD_CMD_RSP_CRC_CHECK_EN
    begin
      logic exp_err;
      exp_err = 1'b0;
      if (len == 48 && idx != 6'd41)
        exp_err = crc7_of({88'b0, rsp[47:8]}, 40) != rsp[7:1];
      else if (len == 136)
        exp_err = crc7_of({8'b0, rsp[127:8]}, 120) != rsp[7:1];
      check({tag, " crc_error"}, {135'b0, crc_error}, {135'b0, exp_err});
    end
`endif
    repeat (3) @(negedge clock);
    check({tag, " strobe_hold"}, {135'b0, strobe_out}, 136'd1);
    if (exit_idle) idle_in = 1'b1;
    else           ack_in  = 1'b1;
    strobe_in = 1'b0;
    @(negedge clock);
    check({tag, " strobe_clr"}, {135'b0, strobe_out}, 136'd0);
    check({tag, " rsp_hold"}, cmd_response, exp_rsp);
    ack_in  = 1'b0;
    idle_in = 1'b0;
  endtask

  initial begin
    logic [5:0]  ridx;
    logic [31:0] rarg;
    int          rlen;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst pin_out", {135'b0, cmd_pin_out}, 136'd1);
    check("rst oe", {135'b0, cmd_pin_oe}, 136'd0);
    check("rst strobe", {135'b0, strobe_out}, 136'd0);
    check("rst ack", {135'b0, ack_out}, 136'd0);
    check("rst timeout", {135'b0, timeout}, 136'd0);
    check("rst rsp", cmd_response, 136'd0);
    reset = 1'b1;
    @(negedge clock);

    // CMD0: known frame, no response
    run_cmd("cmd0", 6'd0, 32'h0, 0, '0, 1'b0);
    check("cmd0 frame", {88'b0, 2'b01, 6'd0, 32'h0, crc7_of(128'h4000000000, 40), 1'b1},
          {88'b0, 48'h4000_0000_0095});

    // CMD8 with canonical R7, then with a corrupted CRC bit
    run_cmd("cmd8", 6'd8, 32'h0000_01AA, 5, {88'b0, 48'h0800_0001_AA13}, 1'b0);
    check("cmd8 frame", {88'b0, 2'b01, 6'd8, 32'h1AA, crc7_of(128'h48000001AA, 40), 1'b1},
          {88'b0, 48'h4800_0001_AA87});
    run_cmd("cmd8_bad", 6'd8, 32'h0000_01AA, 3, {88'b0, 48'h0800_0001_AA11}, 1'b1);

    // CMD2 long response
    run_cmd("cmd2", 6'd2, 32'h0, 2,
            long_rsp({$urandom, $urandom, $urandom, 24'($urandom)}), 1'b0);

    // Timeout, then start bit on the last permitted count
    run_cmd("cmd17_tout", 6'd17, 32'h0, -1, '0, 1'b0);
    run_cmd("ncr63", 6'd17, 32'h1234, 63, short_rsp(6'd17, 32'h0000_0900), 1'b0);

    // Reset during SEND at frame bit 20
    @(negedge clock);
    cmd_to_send = {2'b01, 6'd13, 32'hDEAD_BEEF};
    strobe_in   = 1'b1;
    repeat (1 + 28) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst oe", {135'b0, cmd_pin_oe}, 136'd0);
    check("midrst pin_out", {135'b0, cmd_pin_out}, 136'd1);
    check("midrst strobe", {135'b0, strobe_out}, 136'd0);
    check("midrst ack", {135'b0, ack_out}, 136'd0);
    check("midrst rsp", cmd_response, 136'd0);
    reset     = 1'b1;
    strobe_in = 1'b0;
    @(negedge clock);
    run_cmd("after_rst", 6'd13, 32'hDEAD_BEEF, 1, short_rsp(6'd13, 32'h0000_0900), 1'b0);

    // Randomized commands
    for (int n = 0; n < 8; n++) begin
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom;
      rlen = rsp_len_of(ridx);
      run_cmd($sformatf("rand%0d_idx%0d", n, ridx), ridx, rarg,
              int'($urandom_range(0, 63)),
              (rlen == 136) ? long_rsp({$urandom, $urandom, $urandom, 24'($urandom)})
                            : short_rsp(ridx, $urandom),
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
